// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-FF input synchronizer, 3-sample majority bit voting, configurable
// frame format, and an output FIFO carrying per-frame parity/framing flags.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 28,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  output logic [DATA_BITS-1:0]        m_data,
  output logic                        m_perr,
  output logic                        m_ferr,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy
);

  localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW  = $clog2(DATA_BITS);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned NW  = PW + 1;
  localparam int unsigned EW  = DATA_BITS + 2;
  localparam int unsigned MID = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SMP0      = CW'(MID - 1);
  localparam logic [CW-1:0] SMP1      = CW'(MID);
  localparam logic [CW-1:0] SMP2      = CW'(MID + 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 2);
  localparam logic          HAS_PAR   = (PARITY != 0);
  localparam logic          LATE_SMP  = (MID + 1 == CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  logic                 rx_meta_q, rxs_q;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           smp_q, smp_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        mem_d [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]        count_q, count_d;
  logic                 valid_q, valid_d;
  logic [EW-1:0]        head_q, head_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic          bit_end, s2, vote, ferr_fin, push, pop, full, accept;
  logic [EW-1:0] push_entry;

  // When the third sample lands on the last count it is taken straight from rxs.
  assign bit_end    = (cnt_q == CNT_LAST);
  assign s2         = LATE_SMP ? rxs_q : smp_q[2];
  assign vote       = (smp_q[0] & smp_q[1]) | (smp_q[0] & s2) | (smp_q[1] & s2);
  assign ferr_fin   = ferr_q | ~vote;
  assign push_entry = {shift_q, perr_q, ferr_fin};

  // Frame FSM: bit timing, sampling and field capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    smp_d   = smp_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;

    if (state_q == S_IDLE || state_q == S_WAIT || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_q == SMP0) smp_d[0] = rxs_q;
    if (cnt_q == SMP1) smp_d[1] = rxs_q;
    if (cnt_q == SMP2) smp_d[2] = rxs_q;

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          idx_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) state_d = vote ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = HAS_PAR ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          perr_d  = ((^shift_q) ^ vote) != PAR_ODD;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          ferr_d = ferr_fin;
          if (stop_q == STOP_LAST) begin
            push    = 1'b1;
            state_d = ferr_fin ? S_WAIT : S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output FIFO; the registered head always mirrors the next entry at rd_ptr_d.
  always_comb begin
    pop       = valid_q & m_ready;
    full      = (count_q == FULL_CNT);
    accept    = push & (~full | pop);
    overrun_d = push & full & ~pop;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (accept) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({accept, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase

    valid_d = (count_d != '0);
    if (!valid_d) begin
      head_d = '0;
    end else if (accept && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_entry;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      smp_q     <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      head_q    <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      smp_q     <= smp_d;
      idx_q     <= idx_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign m_data     = head_q[EW-1:2];
  assign m_perr     = head_q[1];
  assign m_ferr     = head_q[0];
  assign m_valid    = valid_q;
  assign fifo_count = count_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: three receivers (8E1, 8O1, 7N2) driven with directed and random
// frames; a frame-level reference model feeds queues checked by per-instance monitors.
module tb_uart_rx_fifo;

  localparam int C = 16;

  typedef struct packed {
    logic       f;
    logic       p;
    logic [8:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rx0, rx1, rx2;
  logic rdy0, rdy1, rdy2;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       p0, p1, p2, f0, f1, f2, v0, v1, v2, ov0, ov1, ov2, b0, b1, b2;
  logic [2:0] cnt0, cnt1, cnt2;

  int vectors     = 0;
  int miscompares = 0;
  int ovc0 = 0, ovc1 = 0, ovc2 = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .m_data(d0), .m_perr(p0), .m_ferr(f0), .m_valid(v0),
    .m_ready(rdy0), .overrun(ov0), .fifo_count(cnt0), .busy(b0));
  uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .m_data(d1), .m_perr(p1), .m_ferr(f1), .m_valid(v1),
    .m_ready(rdy1), .overrun(ov1), .fifo_count(cnt1), .busy(b1));
  uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx2), .m_data(d2), .m_perr(p2), .m_ferr(f2), .m_valid(v2),
    .m_ready(rdy2), .overrun(ov2), .fifo_count(cnt2), .busy(b2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic int dbits_of(input int inst);
    return (inst == 2) ? 7 : 8;
  endfunction
  function automatic int pm_of(input int inst);
    return (inst == 0) ? 1 : ((inst == 1) ? 2 : 0);
  endfunction
  function automatic int ns_of(input int inst);
    return (inst == 2) ? 2 : 1;
  endfunction

  // Reference: expected FIFO entry from the frame contents on the wire.
  function automatic exp_t model(input int inst, input logic [8:0] d, input logic pbit, input logic stopv);
    exp_t e;
    int   ones;
    e.d  = d & 9'((1 << dbits_of(inst)) - 1);
    ones = $countones(e.d) + int'(pbit);
    e.p  = (pm_of(inst) == 0) ? 1'b0 : ((ones % 2) != ((pm_of(inst) == 2) ? 1 : 0));
    e.f  = ~stopv;
    return e;
  endfunction

  function automatic logic [15:0] frame(input int inst, input logic [8:0] d, input logic pbit,
                                        input logic stopv);
    logic [15:0] b;
    int          k;
    b    = '1;
    b[0] = 1'b0;
    k    = 1;
    for (int i = 0; i < dbits_of(inst); i++) begin b[k] = d[i]; k++; end
    if (pm_of(inst) != 0) begin b[k] = pbit; k++; end
    for (int i = 0; i < ns_of(inst); i++) begin b[k] = stopv; k++; end
    return b;
  endfunction

  function automatic int nbits_of(input int inst);
    return 1 + dbits_of(inst) + ((pm_of(inst) != 0) ? 1 : 0) + ns_of(inst);
  endfunction

  function automatic logic good_par(input int inst, input logic [8:0] d);
    return (pm_of(inst) == 2) ? ~(^d[7:0]) : (^d[7:0]);
  endfunction

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic set_rdy(input int inst, input logic v);
    case (inst)
      0:       rdy0 = v;
      1:       rdy1 = v;
      default: rdy2 = v;
    endcase
  endtask

  task automatic push_exp(input int inst, input exp_t e);
    case (inst)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drive(input int inst, input logic [15:0] bits, input int nbits, input int glitch);
    for (int i = 0; i < nbits * C; i++) begin
      set_rx(inst, bits[i / C] ^ (i == glitch));
      @(negedge clk);
    end
  endtask

  task automatic hold(input int inst, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(inst, v);
      @(negedge clk);
    end
  endtask

  task automatic send(input int inst, input logic [8:0] d, input logic pbit, input logic stopv,
                      input int glitch, input bit keep);
    if (keep) push_exp(inst, model(inst, d, pbit, stopv));
    drive(inst, frame(inst, d, pbit, stopv), nbits_of(inst), glitch);
  endtask

  task automatic drain();
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    repeat (8) @(negedge clk);
    rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    @(negedge clk);
    check("q0_left", 32'(q0.size()), 0);
    check("q1_left", 32'(q1.size()), 0);
    check("q2_left", 32'(q2.size()), 0);
    check("cnt_drained", {cnt0, cnt1, cnt2}, 0);
  endtask

  task automatic rand_frames(input int inst, input int n);
    for (int k = 0; k < n; k++) begin
      logic [8:0] d;
      logic       pbit, stopv;
      d     = 9'($urandom_range(0, 255));
      pbit  = good_par(inst, d) ^ ($urandom_range(0, 9) == 0);
      stopv = ($urandom_range(0, 7) != 0);
      send(inst, d, pbit, stopv, -1, 1'b1);
      hold(inst, 1'b1, stopv ? $urandom_range(1, 5) : $urandom_range(3, 6));
    end
  endtask

  task automatic rand_ready(input int inst, input int n);
    for (int k = 0; k < n; k++) begin
      set_rdy(inst, 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    set_rdy(inst, 1'b0);
  endtask

  // Monitors: a pop is taken at the next posedge whenever valid && ready.
  always begin : mon0
    exp_t e;
    @(negedge clk); #2;
    if (rst_n && v0 && rdy0) begin
      if (q0.size() == 0) check("pop0_unexpected", 32'({f0, p0, d0}), 32'hFFFF_FFFF);
      else begin e = q0.pop_front(); check("head0", 32'({f0, p0, d0}), 32'({e.f, e.p, e.d[7:0]})); end
    end
  end
  always begin : mon1
    exp_t e;
    @(negedge clk); #2;
    if (rst_n && v1 && rdy1) begin
      if (q1.size() == 0) check("pop1_unexpected", 32'({f1, p1, d1}), 32'hFFFF_FFFF);
      else begin e = q1.pop_front(); check("head1", 32'({f1, p1, d1}), 32'({e.f, e.p, e.d[7:0]})); end
    end
  end
  always begin : mon2
    exp_t e;
    @(negedge clk); #2;
    if (rst_n && v2 && rdy2) begin
      if (q2.size() == 0) check("pop2_unexpected", 32'({f2, p2, d2}), 32'hFFFF_FFFF);
      else begin e = q2.pop_front(); check("head2", 32'({f2, p2, d2}), 32'({e.f, e.p, e.d[6:0]})); end
    end
  end

  always @(negedge clk) begin
    if (ov0) ovc0 <= ovc0 + 1;
    if (ov1) ovc1 <= ovc1 + 1;
    if (ov2) ovc2 <= ovc2 + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    repeat (4) @(negedge clk);
    check("reset0", {d0, p0, f0, v0, ov0, cnt0, b0}, 0);
    check("reset1", {d1, p1, f1, v1, ov1, cnt1, b1}, 0);
    check("reset2", {d2, p2, f2, v2, ov2, cnt2, b2}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame with push latency: frame is 11*C cycles from START entry.
    send(0, 9'h0A5, 1'b0, 1'b1, -1, 1'b1);
    repeat (2) @(negedge clk);
    check("valid_early", 32'(v0), 0);
    @(negedge clk);
    check("valid_on_time", 32'(v0), 1);
    check("single_head", {cnt0, p0, f0, d0}, {3'd1, 1'b0, 1'b0, 8'hA5});
    rdy0 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
    check("after_pop", {cnt0, v0, d0}, 0);

    // Parity errors on both parity modes.
    hold(0, 1'b1, 4);
    fork
      send(0, 9'h003, 1'b1, 1'b1, -1, 1'b1);
      send(1, 9'h001, 1'b0, 1'b1, -1, 1'b1);
    join
    send(1, 9'h001, 1'b1, 1'b1, -1, 1'b1);
    hold(1, 1'b1, 6);
    check("perr_head0", {p0, d0}, {1'b1, 8'h03});
    check("cnt_odd", 32'(cnt1), 2);
    drain();

    // Framing error: stop bit held low 40 cycles, then recovery and a clean frame.
    push_exp(0, model(0, 9'h055, 1'b0, 1'b0));
    drive(0, frame(0, 9'h055, 1'b0, 1'b0), 10, -1);
    hold(0, 1'b0, 40);
    hold(0, 1'b1, 20);
    send(0, 9'h012, 1'b0, 1'b1, -1, 1'b1);
    hold(0, 1'b1, 5);
    check("ferr_cnt", 32'(cnt0), 2);
    check("ferr_head", {f0, d0}, {1'b1, 8'h55});
    drain();

    // False start from a short pulse, then a glitch mid data bit 3.
    hold(0, 1'b0, 5);
    check("false_start_busy", 32'(b0), 1);
    hold(0, 1'b1, 40);
    check("false_start_idle", {b0, cnt0}, 0);
    send(0, 9'h0C3, good_par(0, 9'h0C3), 1'b1, 4 * C + 9, 1'b1);
    hold(0, 1'b1, 5);
    check("glitch_cnt", 32'(cnt0), 1);
    drain();

    // Overrun: five back-to-back frames into a four-entry FIFO.
    for (int k = 0; k < 5; k++) send(0, 9'(16 + k), good_par(0, 9'(16 + k)), 1'b1, -1, k < 4);
    hold(0, 1'b1, 12);
    check("overrun_cnt", 32'(cnt0), 4);
    check("overrun_pulses", 32'(ovc0), 1);
    drain();

    // 7N2 format, then reset mid data bit.
    send(2, 9'h07F, 1'b0, 1'b1, -1, 1'b1);
    hold(2, 1'b1, 4);
    check("fmt_head", {cnt2, d2}, {3'd1, 7'h7F});
    hold(2, 1'b0, C);
    hold(2, 1'b1, C / 2);
    check("busy_before_rst", 32'(b2), 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset", {d2, p2, f2, v2, ov2, cnt2, b2}, 0);
    q2.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(2, 1'b1, 10);
    send(2, 9'h015, 1'b0, 1'b1, -1, 1'b1);
    hold(2, 1'b1, 4);
    check("post_rst_head", {cnt2, d2}, {3'd1, 7'h15});
    drain();

    // Random traffic with random consumer back-pressure.
    fork
      rand_frames(0, 12);
      rand_frames(1, 12);
      rand_ready(0, 2400);
      rand_ready(1, 2400);
    join
    drain();
    check("overrun_total", {ovc0[7:0], ovc1[7:0], ovc2[7:0]}, {8'd1, 8'd0, 8'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
